sad_column_builder: RTL and testbench

- Producer stage for the column popcount adder.
- Collects a current-block and a reference-block binary pixel stream, NBEAT_W bits per beat, and forms the per-pixel difference bits (XOR).
- Packs NDATA_IN difference bits into one column word and hands it to the downstream adder over a valid/ready interface.
- Holds one registered output column, so the next column can be assembled while the current one waits.

---
 rtl/sad_column_builder.sv | 101 ++++++++++
 tb/tb_sad_column_builder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sad_column_builder.sv
// sad_column_builder: packs XOR difference bits of two pixel streams into columns for the popcount adder
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   clear                 synchronous abort of the partially assembled column
//   in_valid/in_ready     beat handshake; in_cur/in_ref carry NBEAT_W pixel bits each
//   out_valid/out_ready   column handshake; out_col holds NDATA_IN difference bits
//   out_idx               column index, only when COLBUILD_IDX_EN is defined
// Optional feature macro: COLBUILD_IDX_EN
module sad_column_builder #(
    parameter int NDATA_IN = 100,
    parameter int NBEAT_W  = 10,
    parameter int NCOL     = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NBEAT_W-1:0]  in_cur,
    input  logic [NBEAT_W-1:0]  in_ref,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NDATA_IN-1:0] out_col
`ifdef COLBUILD_IDX_EN
    ,
    output logic [$clog2(NCOL)-1:0] out_idx
`endif
);
    localparam int NBEAT = NDATA_IN / NBEAT_W;
    localparam int BCNT_W = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam logic [BCNT_W-1:0] LAST = BCNT_W'(NBEAT - 1);

    if ((NDATA_IN % NBEAT_W) != 0 || NCOL < 1) begin : g_bad_cfg
        $error("sad_column_builder: NDATA_IN must be a multiple of NBEAT_W and NCOL >= 1");
    end

    logic [BCNT_W-1:0]   cnt_q, cnt_d;
    logic [NDATA_IN-1:0] asm_q, asm_d;
    logic [NDATA_IN-1:0] out_col_q, out_col_d;
    logic                out_valid_q, out_valid_d;
    logic [NBEAT_W-1:0]  diff;
    logic                last, accept, load;

    assign diff     = in_cur ^ in_ref;
    assign last     = cnt_q == LAST;
    // Only the last-beat slot can stall: it needs the output register free.
    assign in_ready = !last || !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready && !clear;
    assign load     = accept && last;

    always_comb begin
        asm_d = asm_q;
        for (int k = 0; k < NBEAT; k++)
            if (accept && cnt_q == BCNT_W'(k))
                asm_d[k*NBEAT_W +: NBEAT_W] = diff;
        cnt_d       = clear ? '0 : !accept ? cnt_q : last ? '0 : cnt_q + 1'b1;
        out_valid_d = load || (out_valid_q && !out_ready);
        // asm_d already carries the last slice, so the column bypasses asm_q.
        out_col_d   = load ? asm_d : out_col_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            asm_q       <= '0;
            out_col_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            asm_q       <= asm_d;
            out_col_q   <= out_col_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_col   = out_col_q;

`ifdef COLBUILD_IDX_EN
    localparam int IDX_W = $clog2(NCOL);

    logic [IDX_W-1:0] idx_q, idx_d, out_idx_q, out_idx_d;

    always_comb begin
        idx_d     = clear ? '0 : !load ? idx_q : (idx_q == IDX_W'(NCOL - 1)) ? '0 : idx_q + 1'b1;
        out_idx_d = load ? idx_q : out_idx_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= '0;
            out_idx_q <= '0;
        end else begin
            idx_q     <= idx_d;
            out_idx_q <= out_idx_d;
        end
    end

    assign out_idx = out_idx_q;
`endif
endmodule

// File: tb/tb_sad_column_builder.sv
// tb_sad_column_builder: directed self-checking bench for sad_column_builder
module tb_sad_column_builder;
    logic        clk = 1'b0;
    logic        rst_n, clear, in_valid, in_ready, out_valid, out_ready;
    logic [9:0]  in_cur, in_ref;
    logic [99:0] out_col;
    int          n_checks = 0;
    int          n_fail = 0;
`ifdef COLBUILD_IDX_EN
    logic [1:0]  out_idx;
    int          exp_idx [5] = '{0, 1, 2, 3, 0};
`endif

    sad_column_builder #(.NDATA_IN(100), .NBEAT_W(10), .NCOL(4)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_cur(in_cur), .in_ref(in_ref),
        .out_valid(out_valid), .out_ready(out_ready), .out_col(out_col)
`ifdef COLBUILD_IDX_EN
        , .out_idx(out_idx)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [9:0] c, input logic [9:0] r);
        int n;
        in_valid = 1'b1;
        in_cur   = c;
        in_ref   = r;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) check("push_timeout", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic push_col(input logic [9:0] c, input logic [9:0] r);
        for (int k = 0; k < 10; k++) push(c, r);
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_cur = '0; in_ref = '0;
        #12;
        check("rst_valid", out_valid, 0);
        check("rst_col", out_col, 0);
        check("rst_ready", in_ready, 1);
        rst_n = 1'b1;
        tick();

        // identical streams
        for (int k = 0; k < 10; k++) begin
            push(10'h2A5, 10'h2A5);
            if (k == 8) check("same_early", out_valid, 0);
        end
        check("same_valid", out_valid, 1);
        check("same_col", out_col, 0);
`ifdef COLBUILD_IDX_EN
        check("same_idx", out_idx, 0);
`endif
        tick();
        check("same_drop", out_valid, 0);

        // alternating pattern
        for (int k = 0; k < 10; k++)
            if (k % 2 == 0) push(10'h3FF, 10'h000);
            else push(10'h155, 10'h155);
        check("pat_valid", out_valid, 1);
        check("pat_col", out_col, {10'h0, 10'h3FF, 10'h0, 10'h3FF, 10'h0, 10'h3FF, 10'h0, 10'h3FF, 10'h0, 10'h3FF});
        tick();

        // backpressure
        out_ready = 1'b0;
        push_col(10'h0F0, 10'h000);
        check("bp_a_valid", out_valid, 1);
        check("bp_a_col", out_col, {10{10'h0F0}});
        for (int k = 0; k < 9; k++) push(10'h00F, 10'h000);
        check("bp_ready_low", in_ready, 0);
        check("bp_a_hold", out_col, {10{10'h0F0}});
        in_valid = 1'b1; in_cur = 10'h00F; in_ref = 10'h000;
        tick();
        check("bp_stall_ready", in_ready, 0);
        check("bp_stall_valid", out_valid, 1);
        check("bp_stall_col", out_col, {10{10'h0F0}});
        out_ready = 1'b1;
        #1;
        check("bp_ready_comb", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("bp_swap_valid", out_valid, 1);
        check("bp_swap_col", out_col, {10{10'h00F}});
        tick();
        check("bp_b_drop", out_valid, 0);

        // clear mid-column
        for (int k = 0; k < 4; k++) push(10'h155, 10'h000);
        clear = 1'b1; in_valid = 1'b1; in_cur = 10'h3FF; in_ref = 10'h000;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            push(10'h3FF, 10'h000);
            if (k == 8) check("clr_early", out_valid, 0);
        end
        check("clr_valid", out_valid, 1);
        check("clr_col", out_col, {100{1'b1}});
`ifdef COLBUILD_IDX_EN
        check("clr_idx", out_idx, 0);
`endif
        tick();

        // clear in last-beat slot
        for (int k = 0; k < 9; k++) push(10'h3FF, 10'h000);
        clear = 1'b1; in_valid = 1'b1;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        check("clr_last_none", out_valid, 0);
        push_col(10'h2A5, 10'h000);
        check("clr_last_col", out_col, {10{10'h2A5}});
        tick();

        // clear leaves pending column alone
        out_ready = 1'b0;
        push_col(10'h001, 10'h000);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_pend_valid", out_valid, 1);
        check("clr_pend_col", out_col, {10{10'h001}});
        out_ready = 1'b1;
        tick();
        check("clr_pend_drop", out_valid, 0);

        // asynchronous reset mid-column
        out_ready = 1'b0;
        push_col(10'h0F0, 10'h000);
        for (int k = 0; k < 6; k++) push(10'h00F, 10'h000);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_col", out_col, 0);
        check("arst_ready", in_ready, 1);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        push_col(10'h1A5, 10'h000);
        check("arst_new_valid", out_valid, 1);
        check("arst_new_col", out_col, {10{10'h1A5}});
`ifdef COLBUILD_IDX_EN
        check("arst_idx", out_idx, 0);
`endif
        tick();

`ifdef COLBUILD_IDX_EN
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int c = 0; c < 5; c++) begin
            push_col(10'h3C3, 10'h000);
            check("idx_seq", out_idx, exp_idx[c]);
        end
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
